// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one size-bit mux among 4 requesters; registers GNT/SEL/OUT/VALID.
// Optional `define HOLD_TIMEOUT_EN limits each grant to HOLD_MAX VALID cycles.
module mux_rr_arbiter #(
  parameter int unsigned size     = 1,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          REQ,
  input  logic [4*size-1:0]   DATA_IN,
  output logic [3:0]          GNT,
  output logic [1:0]          SEL,
  output logic [size-1:0]     OUT,
  output logic                VALID
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr, ptr_nxt;
  logic [3:0]      gnt_nxt;
  logic [1:0]      sel_nxt;
  logic [size-1:0] out_nxt;
  logic            valid_nxt;

  logic [1:0]      ptr_srch;
  logic [1:0]      idx;
  logic [1:0]      win;
  logic            found;
  logic            release_now;
  logic            hold_expired;
  logic [size-1:0] data_sel;

  if (size < 1 || HOLD_MAX < 1) begin : g_param_check
    $error("mux_rr_arbiter: size and HOLD_MAX must be at least 1");
  end

`ifdef HOLD_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hcnt, hcnt_nxt;
  assign hold_expired = (hcnt == HW'(HOLD_MAX));
`else
  assign hold_expired = 1'b0;
`endif

  assign data_sel    = DATA_IN[SEL*size +: size];
  assign release_now = (state == GRANT) && (!REQ[SEL] || hold_expired);
  // On release the search restarts just past the departing requester,
  // which is exactly the new PTR, so the hand-over costs no extra edge.
  assign ptr_srch    = (state == GRANT) ? SEL + 2'd1 : ptr;

  always_comb begin
    found = 1'b0;
    win   = ptr_srch;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_srch + 2'(k);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      GNT   <= '0;
      SEL   <= '0;
      OUT   <= '0;
      VALID <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hcnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      GNT   <= gnt_nxt;
      SEL   <= sel_nxt;
      OUT   <= out_nxt;
      VALID <= valid_nxt;
`ifdef HOLD_TIMEOUT_EN
      hcnt  <= hcnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
`ifdef HOLD_TIMEOUT_EN
    hcnt_nxt  = hcnt;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
`ifdef HOLD_TIMEOUT_EN
          hcnt_nxt  = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_nxt = SEL + 2'd1;
          if (!found) state_nxt = IDLE;
`ifdef HOLD_TIMEOUT_EN
          hcnt_nxt = '0;
`endif
        end else begin
`ifdef HOLD_TIMEOUT_EN
          hcnt_nxt = hcnt + HW'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt   = GNT;
    sel_nxt   = SEL;
    out_nxt   = OUT;
    valid_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt = 4'b0001 << win;
          sel_nxt = win;
        end
      end
      GRANT: begin
        if (!release_now) begin
          out_nxt   = data_sel;
          valid_nxt = 1'b1;
        end else if (found) begin
          gnt_nxt = 4'b0001 << win;
          sel_nxt = win;
        end else begin
          gnt_nxt = '0;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter (size=4, HOLD_MAX=3): directed scenarios plus random traffic
// against a queue-free arithmetic reference model; honours `define HOLD_TIMEOUT_EN.
module tb_mux_rr_arbiter;
  localparam int unsigned SIZE = 4;
  localparam int unsigned HOLD = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [15:0] DATA_IN;
  logic [3:0]  GNT;
  logic [1:0]  SEL;
  logic [3:0]  OUT;
  logic        VALID;

  mux_rr_arbiter #(.size(SIZE), .HOLD_MAX(HOLD)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA_IN(DATA_IN),
    .GNT(GNT), .SEL(SEL), .OUT(OUT), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: granted requester (-1 = none), pointer, outputs
  int         m_gnt = -1;
  int         m_sel = 0;
  int         m_ptr = 0;
  int         m_hcnt = 0;
  int         m_vcnt = 0;
  bit         m_new = 0;
  logic [3:0] m_out = '0;
  logic       m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    bit expired;
    m_new = 0;
    if (RST) begin
      m_gnt = -1; m_sel = 0; m_ptr = 0; m_hcnt = 0; m_vcnt = 0;
      m_out = '0; m_valid = 1'b0;
      return;
    end
    if (m_gnt < 0) begin
      m_gnt = pick(REQ, m_ptr);
      m_valid = 1'b0;
      if (m_gnt >= 0) begin m_sel = m_gnt; m_hcnt = 0; m_vcnt = 0; m_new = 1; end
    end else begin
      expired = 0;
`ifdef HOLD_TIMEOUT_EN
      expired = (m_hcnt == HOLD);
`endif
      if (REQ[m_gnt] && !expired) begin
        m_out = DATA_IN[m_gnt*SIZE +: SIZE];
        m_valid = 1'b1;
        m_hcnt++;
        m_vcnt++;
      end else begin
        m_valid = 1'b0;
        m_ptr = (m_gnt + 1) % 4;
        m_gnt = pick(REQ, m_ptr);
        if (m_gnt >= 0) begin m_sel = m_gnt; m_hcnt = 0; m_vcnt = 0; m_new = 1; end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    check("gnt",   32'(GNT),   (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
    check("sel",   32'(SEL),   32'(m_sel));
    check("out",   32'(OUT),   32'(m_out));
    check("valid", 32'(VALID), 32'(m_valid));
  endtask

  initial begin
    int nord;
    int vcount;
    int hold_t [4];

    // reset with all requesting, then first grant goes to requester 0
    RST = 1'b1; REQ = 4'b1111; DATA_IN = 16'($urandom);
    tick(); tick();
    check("t1_rst_gnt", 32'(GNT), 32'd0);
    RST = 1'b0;
    tick();
    check("t1_first_gnt", 32'(GNT), 32'b0001);

    // single requester 2
    REQ = 4'b0000; tick();
    REQ = 4'b0100; DATA_IN = 16'($urandom); DATA_IN[11:8] = 4'hA;
    tick();
    check("t2_gnt", 32'(GNT), 32'b0100);
    check("t2_sel", 32'(SEL), 32'd2);
    tick();
    check("t2_out",   32'(OUT),   32'hA);
    check("t2_valid", 32'(VALID), 32'd1);
    REQ = 4'b0000; tick();
    check("t2_rel_valid", 32'(VALID), 32'd0);
    check("t2_rel_gnt",   32'(GNT),   32'd0);

    // PTR is now 3: simultaneous 0 and 3 resolves to 3, then wraps to 0
    REQ = 4'b1001; DATA_IN = 16'($urandom); tick();
    check("t4_gnt3", 32'(GNT), 32'b1000);
    tick();
    REQ = 4'b0001; tick();
    check("t4_gnt0", 32'(GNT), 32'b0001);
    tick();
    REQ = 4'b0000; tick();
    REQ = 4'b1001; tick();
    check("t4_ptr1", 32'(GNT), 32'b1000);
    REQ = 4'b0000; tick(); tick();

    // rotation: each grantee drops after 2 VALID cycles and reasserts
    RST = 1'b1; tick(); RST = 1'b0;
    REQ = 4'b1111;
    nord = 0;
    for (int t = 0; t < 80 && nord < 5; t++) begin
      REQ = 4'b1111;
      if (m_gnt >= 0 && m_vcnt >= 2) REQ[m_gnt] = 1'b0;
      DATA_IN = 16'($urandom);
      tick();
      if (m_new) begin
        check("t3_order", 32'(SEL), 32'(nord % 4));
        nord++;
      end
    end
    check("t3_grants", 32'(nord), 32'd5);

    // mid-grant reset
    REQ = 4'b1111; tick();
    RST = 1'b1; tick();
    check("t6_gnt",   32'(GNT),   32'd0);
    check("t6_valid", 32'(VALID), 32'd0);
    check("t6_out",   32'(OUT),   32'd0);
    RST = 1'b0; tick();
    check("t6_regrant", 32'(GNT), 32'b0001);

    // hold behaviour with two steady requesters
    RST = 1'b1; tick(); RST = 1'b0;
    REQ = 4'b0011;
    vcount = 0;
    for (int t = 0; t < 14; t++) begin
      DATA_IN = 16'($urandom);
      tick();
      if (VALID === 1'b1) vcount++;
    end
`ifdef HOLD_TIMEOUT_EN
    check("t5_valid_cycles", 32'(vcount), 32'd10);
`else
    check("t5_valid_cycles", 32'(vcount), 32'd13);
`endif

    // random traffic
    RST = 1'b1; REQ = '0; tick(); RST = 1'b0;
    for (int i = 0; i < 4; i++) hold_t[i] = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!REQ[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            REQ[i] = 1'b1;
            hold_t[i] = int'($urandom_range(1, 6));
          end
        end else if (m_gnt == i && m_vcnt >= hold_t[i]) begin
          REQ[i] = 1'b0;
        end
      end
      DATA_IN = 16'($urandom);
      RST = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
